stp_word_assembler: RTL and testbench

//  Parametrised serial-to-parallel word assembler: shifts in serial bits, counts them,
//  and hands each complete NUM_BITS word to a downstream consumer via valid/ready.

---
 rtl/stp_word_assembler_pkg.sv | 25 ++
 rtl/stp_word_assembler_if.sv | 24 ++
 rtl/stp_word_assembler_shift_core.sv | 54 +++++
 rtl/stp_word_assembler.sv | 130 +++++++++++++
 tb/tb_stp_word_assembler.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/stp_word_assembler_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel word assembler.
// Optional feature macro: PARITY_CHECK_EN (one trailing parity bit per word).
package stp_pkg;

   typedef enum logic {
      SHIFT_TO_LSB = 1'b0,
      SHIFT_TO_MSB = 1'b1
   } shift_dir_e;

`ifdef PARITY_CHECK_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // Serial bits per word, including the parity bit when it is enabled.
   function automatic int word_len(input int num_bits);
      return num_bits + PARITY_BITS;
   endfunction

   function automatic int cnt_width(input int wlen);
      return $clog2(wlen + 1);
   endfunction

endpackage

// File: rtl/stp_word_assembler_if.sv
// Word-side handshake between the assembler (master) and its consumer (slave).
// Optional feature macro: PARITY_CHECK_EN (drives parity_err when defined).
interface stp_word_if #(
   parameter int NUM_BITS = 8
);
   logic [NUM_BITS-1:0] parallel_out;
   logic                word_valid;
   logic                word_ready;
   logic                parity_err;

   modport master (
      output parallel_out,
      output word_valid,
      output parity_err,
      input  word_ready
   );

   modport slave (
      input  parallel_out,
      input  word_valid,
      input  parity_err,
      output word_ready
   );
endinterface

// File: rtl/stp_word_assembler_shift_core.sv
// Shift register for the assembler: shifts toward MSB or LSB, clear reloads all ones.
// Optional feature macro: PARITY_CHECK_EN (handled by the caller, not here).
module stp_shift_core
   import stp_pkg::*;
#(
   parameter int         NUM_BITS  = 8,
   parameter shift_dir_e SHIFT_DIR = SHIFT_TO_MSB
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clear,
   input  logic                i_shift,
   input  logic                i_bit,
   output logic [NUM_BITS-1:0] o_sr,
   output logic [NUM_BITS-1:0] o_shifted
);

   logic [NUM_BITS-1:0] r_sr;
   logic [NUM_BITS-1:0] w_base;
   logic [NUM_BITS-1:0] w_shifted;
   logic [NUM_BITS-1:0] w_next;

   // A clear coinciding with a shift makes the incoming bit the first of a fresh word.
   assign w_base = i_clear ? '1 : r_sr;

   generate
      if (SHIFT_DIR == SHIFT_TO_MSB) begin : g_to_msb
         assign w_shifted = {w_base[NUM_BITS-2:0], i_bit};
      end else begin : g_to_lsb
         assign w_shifted = {i_bit, w_base[NUM_BITS-1:1]};
      end
   endgenerate

   always_comb begin
      w_next = r_sr;
      if (i_shift) begin
         w_next = w_shifted;
      end else if (i_clear) begin
         w_next = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sr <= '1;
      end else begin
         r_sr <= w_next;
      end
   end

   assign o_sr      = r_sr;
   assign o_shifted = w_shifted;

endmodule

// File: rtl/stp_word_assembler.sv
// Serial-to-parallel word assembler with a one-word holding register and valid/ready output.
// Optional feature macro: PARITY_CHECK_EN (adds a checked parity bit after each data word).
module stp_word_assembler
   import stp_pkg::*;
#(
   parameter int NUM_BITS   = 8,
   parameter bit SHIFT_MSB  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       i_shift_enable,
   input  logic                                       i_serial_in,
   input  logic                                       i_frame_start,
   input  logic                                       i_clear_overrun,
   stp_word_if.master                                 o_word,
   output logic                                       o_overrun,
   output logic [cnt_width(word_len(NUM_BITS))-1:0]   o_bit_count
);

   localparam int               WORD_LEN = word_len(NUM_BITS);
   localparam int               CNT_W    = cnt_width(WORD_LEN);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_LEN - 1);

   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_next;
   logic [NUM_BITS-1:0] r_hold;
   logic                r_valid;
   logic                r_overrun;
   logic                r_par_err;

   logic                w_last;
   logic                w_complete;
   logic                w_load;
   logic                w_drop;
   logic                w_data_shift;
   logic [NUM_BITS-1:0] w_sr;
   logic [NUM_BITS-1:0] w_shifted;
   logic [NUM_BITS-1:0] w_word;
   logic                w_par_err;

   assign w_last     = (r_cnt == LAST_CNT);
   assign w_complete = i_shift_enable & ~i_frame_start & w_last;
   assign w_load     = w_complete & (~r_valid | o_word.word_ready);
   assign w_drop     = w_complete & r_valid & ~o_word.word_ready;

`ifdef PARITY_CHECK_EN
   logic [NUM_BITS-1:0] w_unused_shifted;

   // The parity bit is consumed by the check and never enters the shift register.
   assign w_data_shift     = i_shift_enable & (i_frame_start | ~w_last);
   assign w_word           = w_sr;
   assign w_par_err        = ((^w_sr) ^ i_serial_in) != PARITY_ODD;
   assign w_unused_shifted = w_shifted;
`else
   logic [NUM_BITS-1:0] w_unused_sr;
   logic                w_unused_par_odd;

   assign w_data_shift     = i_shift_enable;
   assign w_word           = w_shifted;
   assign w_par_err        = 1'b0;
   assign w_unused_sr      = w_sr;
   assign w_unused_par_odd = PARITY_ODD;
`endif

   stp_shift_core #(
      .NUM_BITS  (NUM_BITS),
      .SHIFT_DIR (SHIFT_MSB ? SHIFT_TO_MSB : SHIFT_TO_LSB)
   ) u_shift_core (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (i_frame_start),
      .i_shift   (w_data_shift),
      .i_bit     (i_serial_in),
      .o_sr      (w_sr),
      .o_shifted (w_shifted)
   );

   always_comb begin
      w_cnt_next = r_cnt;
      if (i_shift_enable) begin
         if (i_frame_start) begin
            w_cnt_next = CNT_W'(1);
         end else if (w_last) begin
            w_cnt_next = '0;
         end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
         end
      end else if (i_frame_start) begin
         w_cnt_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_hold    <= '1;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_par_err <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;

         if (w_load) begin
            r_hold    <= w_word;
            r_par_err <= w_par_err;
         end

         // A completion on the transfer edge refills the holding register without a gap.
         if (w_load) begin
            r_valid <= 1'b1;
         end else if (r_valid & o_word.word_ready) begin
            r_valid <= 1'b0;
         end

         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (i_clear_overrun) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign o_word.parallel_out = r_hold;
   assign o_word.word_valid   = r_valid;
   assign o_word.parity_err   = r_par_err;
   assign o_overrun           = r_overrun;
   assign o_bit_count         = r_cnt;

endmodule

// File: tb/tb_stp_word_assembler.sv
// Directed bench for stp_word_assembler: one MSB-first and one LSB-first instance share stimulus.
// Build with PARITY_CHECK_EN defined to run the parity sequence instead of the plain table.
module tb_stp_word_assembler;
   import stp_pkg::*;

   logic       clk;
   logic       rst, se, si, fs, co, rdy;
   logic       ovr_m, ovr_l;
   logic [3:0] cnt_m, cnt_l;
   int         n_tests;
   int         n_fail;

   stp_word_if #(.NUM_BITS(8)) bus_m ();
   stp_word_if #(.NUM_BITS(8)) bus_l ();

   assign bus_m.word_ready = rdy;
   assign bus_l.word_ready = rdy;

   stp_word_assembler #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .PARITY_ODD(1'b0)) dut_m (
      .clk(clk), .rst(rst), .i_shift_enable(se), .i_serial_in(si), .i_frame_start(fs),
      .i_clear_overrun(co), .o_word(bus_m), .o_overrun(ovr_m), .o_bit_count(cnt_m)
   );

   stp_word_assembler #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .PARITY_ODD(1'b0)) dut_l (
      .clk(clk), .rst(rst), .i_shift_enable(se), .i_serial_in(si), .i_frame_start(fs),
      .i_clear_overrun(co), .o_word(bus_l), .o_overrun(ovr_l), .o_bit_count(cnt_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, se, si, fs, co, rdy;
      logic       ev;
      logic [7:0] ed;
      logic [7:0] edl;
      logic       eo;
      logic [3:0] ec;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic s, input logic b, input logic f,
                      input logic c, input logic y);
      rst = r; se = s; si = b; fs = f; co = c; rdy = y;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic r, input logic s, input logic b, input logic f,
                       input logic c, input logic y, input logic v, input logic [7:0] d,
                       input logic [7:0] dl, input logic o, input logic [3:0] n);
      vec_t x;
      x.rst = r; x.se = s; x.si = b; x.fs = f; x.co = c; x.rdy = y;
      x.ev = v; x.ed = d; x.edl = dl; x.eo = o; x.ec = n;
      tbl.push_back(x);
   endtask

   // nb bits of w, MSB first, with outputs expected to hold while the count climbs from c0.
   task automatic push_bits(input logic [7:0] w, input int nb, input logic y, input logic v,
                            input logic [7:0] d, input logic [7:0] dl, input logic o,
                            input int c0);
      for (int k = 0; k < nb; k++) begin
         push(1'b0, 1'b1, w[7-k], 1'b0, 1'b0, y, v, d, dl, o, 4'(c0 + k + 1));
      end
   endtask

`ifdef PARITY_CHECK_EN
   task automatic send_par(input logic [7:0] w, input logic p, input logic [7:0] exp_l,
                           input logic exp_err, input string nm);
      for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, w[7-k], 1'b0, 1'b0, 1'b1);
      chk({nm, " cnt before parity"}, 32'(cnt_m), 32'd8);
      cyc(1'b0, 1'b1, p, 1'b0, 1'b0, 1'b1);
      chk({nm, " valid"}, 32'(bus_m.word_valid), 32'd1);
      chk({nm, " data msb"}, 32'(bus_m.parallel_out), 32'(w));
      chk({nm, " data lsb"}, 32'(bus_l.parallel_out), 32'(exp_l));
      chk({nm, " parity_err"}, 32'(bus_m.parity_err), 32'(exp_err));
      chk({nm, " cnt wrap"}, 32'(cnt_m), 32'd0);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1; se = 1'b0; si = 1'b0; fs = 1'b0; co = 1'b0; rdy = 1'b1;

`ifdef PARITY_CHECK_EN
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("par rst data", 32'(bus_m.parallel_out), 32'hFF);
      chk("par rst perr", 32'(bus_m.parity_err), 32'd0);
      send_par(8'h01, 1'b1, 8'h80, 1'b0, "par good");
      send_par(8'h01, 1'b0, 8'h80, 1'b1, "par bad");
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("par mid cnt", 32'(cnt_m), 32'd3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("par rst mid cnt", 32'(cnt_m), 32'd0);
      chk("par rst mid valid", 32'(bus_m.word_valid), 32'd0);
      send_par(8'hA5, 1'b0, 8'hA5, 1'b0, "par after rst");
`else
      // Reset
      push(1, 0, 0, 0, 0, 1, 0, 8'hFF, 8'hFF, 0, 0);
      push(1, 0, 0, 0, 0, 1, 0, 8'hFF, 8'hFF, 0, 0);
      // A5 with ready: valid for exactly one cycle
      push_bits(8'hA5, 7, 1, 0, 8'hFF, 8'hFF, 0, 0);
      push(0, 1, 1, 0, 0, 1, 1, 8'hA5, 8'hA5, 0, 0);
      push(0, 0, 0, 0, 0, 1, 0, 8'hA5, 8'hA5, 0, 0);
      // Bits 1,1,0,0,0,0,0,0: C0 MSB-first, 03 LSB-first
      push_bits(8'hC0, 7, 1, 0, 8'hA5, 8'hA5, 0, 0);
      push(0, 1, 0, 0, 0, 1, 1, 8'hC0, 8'h03, 0, 0);
      push(0, 0, 0, 0, 0, 1, 0, 8'hC0, 8'h03, 0, 0);
      // Consumer stalled: 3C held, C3 dropped, overrun sticky then cleared
      push_bits(8'h3C, 7, 0, 0, 8'hC0, 8'h03, 0, 0);
      push(0, 1, 0, 0, 0, 0, 1, 8'h3C, 8'h3C, 0, 0);
      push_bits(8'hC3, 7, 0, 1, 8'h3C, 8'h3C, 0, 0);
      push(0, 1, 1, 0, 0, 0, 1, 8'h3C, 8'h3C, 1, 0);
      push(0, 0, 0, 0, 0, 0, 1, 8'h3C, 8'h3C, 1, 0);
      push(0, 0, 0, 0, 1, 0, 1, 8'h3C, 8'h3C, 0, 0);
      push(0, 0, 0, 0, 0, 1, 0, 8'h3C, 8'h3C, 0, 0);
      // Partial word, frame_start, then 5A; 81 completes on the transfer edge
      push_bits(8'hE0, 3, 1, 0, 8'h3C, 8'h3C, 0, 0);
      push(0, 0, 0, 1, 0, 1, 0, 8'h3C, 8'h3C, 0, 0);
      push_bits(8'h5A, 7, 1, 0, 8'h3C, 8'h3C, 0, 0);
      push(0, 1, 0, 0, 0, 1, 1, 8'h5A, 8'h5A, 0, 0);
      push_bits(8'h81, 7, 0, 1, 8'h5A, 8'h5A, 0, 0);
      push(0, 1, 1, 0, 0, 1, 1, 8'h81, 8'h81, 0, 0);
      push(0, 0, 0, 0, 0, 1, 0, 8'h81, 8'h81, 0, 0);
      // frame_start with shift: that bit starts the new word (F0 / 0F)
      push_bits(8'h00, 2, 1, 0, 8'h81, 8'h81, 0, 0);
      push(0, 1, 1, 1, 0, 1, 0, 8'h81, 8'h81, 0, 1);
      push_bits(8'hE0, 6, 1, 0, 8'h81, 8'h81, 0, 1);
      push(0, 1, 0, 0, 0, 0, 1, 8'hF0, 8'h0F, 0, 0);
      // clear_overrun on the same edge as a new overrun: overrun stays set
      push_bits(8'h00, 7, 0, 1, 8'hF0, 8'h0F, 0, 0);
      push(0, 1, 0, 0, 1, 0, 1, 8'hF0, 8'h0F, 1, 0);
      push(0, 0, 0, 0, 1, 0, 1, 8'hF0, 8'h0F, 0, 0);
      push(0, 0, 0, 0, 0, 1, 0, 8'hF0, 8'h0F, 0, 0);
      // Hold with shift_enable low, reset mid-word dominates a shift, then 96 / 69
      push_bits(8'h00, 3, 1, 0, 8'hF0, 8'h0F, 0, 0);
      push(0, 0, 1, 0, 0, 1, 0, 8'hF0, 8'h0F, 0, 3);
      push(1, 1, 1, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);
      push_bits(8'h96, 7, 1, 0, 8'hFF, 8'hFF, 0, 0);
      push(0, 1, 0, 0, 0, 1, 1, 8'h96, 8'h69, 0, 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].rst, tbl[i].se, tbl[i].si, tbl[i].fs, tbl[i].co, tbl[i].rdy);
         chk($sformatf("row%0d valid", i), 32'(bus_m.word_valid), 32'(tbl[i].ev));
         chk($sformatf("row%0d data msb", i), 32'(bus_m.parallel_out), 32'(tbl[i].ed));
         chk($sformatf("row%0d overrun", i), 32'(ovr_m), 32'(tbl[i].eo));
         chk($sformatf("row%0d bit_count", i), 32'(cnt_m), 32'(tbl[i].ec));
         chk($sformatf("row%0d parity_err", i), 32'(bus_m.parity_err), 32'd0);
         chk($sformatf("row%0d valid lsb", i), 32'(bus_l.word_valid), 32'(tbl[i].ev));
         chk($sformatf("row%0d data lsb", i), 32'(bus_l.parallel_out), 32'(tbl[i].edl));
         chk($sformatf("row%0d overrun lsb", i), 32'(ovr_l), 32'(tbl[i].eo));
         chk($sformatf("row%0d bit_count lsb", i), 32'(cnt_l), 32'(tbl[i].ec));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
